// File: rtl/multicycle_control_fsm.sv
// Multicycle main control unit for the 16-bit CPU.
// It steps each instruction through fetch, decode, execute, memory and
// writeback, and drives the datapath enables for each step. It also latches
// the instruction register, which supplies opcode and Funct to the ALU
// control unit. Memory accesses use a ready handshake with a timeout abort.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN. When it is defined, an
// undefined opcode sends the FSM to TRAP, and the illegal_op port is added.
module multicycle_control_fsm #(
    parameter int TIMEOUT_CYCLES    = 15,
    parameter int RESET_STATE_FETCH = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        zero,
    output logic [1:0]  ALUOp,
    output logic [3:0]  opcode,
    output logic [1:0]  Funct,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_source,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        bus_error,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic        illegal_op,
`endif
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        WB_R     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        EXEC_I   = 4'd10,
        WB_I     = 4'd11,
        TRAP     = 4'd12
    } state_t;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_LW   = 4'b0001;
    localparam logic [3:0] OP_SHFT = 4'b0010;
    localparam logic [3:0] OP_SW   = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_J    = 4'b0101;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_SUBI = 4'b1010;
    localparam logic [3:0] OP_SLTI = 4'b1011;

    localparam logic [7:0] TIMEOUT_COUNT = 8'(TIMEOUT_CYCLES);
    // The FSM always leaves reset in FETCH. The parameter is fixed at 1.
    localparam state_t     RESET_STATE   = (RESET_STATE_FETCH == 1) ? FETCH : FETCH;

    state_t      state_r;
    state_t      next_state_s;
    logic [15:0] ir_r;
    logic [7:0]  wait_cnt_r;
    logic        wait_state_s;
    logic        timeout_s;
    logic        ir_load_s;
    logic        unused_ir_bits_s;

    // IR[11:2] carries register and immediate fields. The datapath decodes
    // them, and this unit does not use them.
    assign unused_ir_bits_s = ^ir_r[11:2];

    // Next-state and output decode. While reset is high, every output is held at 0.
    always_comb begin
        next_state_s  = state_r;
        ALUOp         = 2'b00;
        opcode        = ir_r[15:12];
        Funct         = ir_r[1:0];
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        bus_error     = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_op    = 1'b0;
`endif
        state_dbg     = state_r;
        ir_load_s     = 1'b0;
        wait_state_s  = (state_r == FETCH) || (state_r == MEM_RD) || (state_r == MEM_WR);
        timeout_s     = wait_state_s && !mem_ready && (wait_cnt_r == TIMEOUT_COUNT);

        if (reset) begin
            opcode       = 4'b0000;
            Funct        = 2'b00;
            state_dbg    = 4'd0;
            timeout_s    = 1'b0;
            next_state_s = RESET_STATE;
        end else begin
            bus_error = timeout_s;
            case (state_r)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write     = 1'b1;
                        pc_write     = 1'b1;
                        ir_load_s    = 1'b1;
                        next_state_s = DECODE;
                    end else begin
                        next_state_s = FETCH;
                    end
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    case (ir_r[15:12])
                        OP_R:                             next_state_s = EXEC_R;
                        OP_LW, OP_SW:                     next_state_s = MEM_ADDR;
                        OP_BEQ:                           next_state_s = BRANCH;
                        OP_J:                             next_state_s = JUMP;
                        OP_ADDI, OP_SUBI, OP_SLTI, OP_SHFT: next_state_s = EXEC_I;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        default:                          next_state_s = TRAP;
`else
                        default:                          next_state_s = FETCH;
`endif
                    endcase
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (ir_r[15:12] == OP_SW) begin
                        next_state_s = MEM_WR;
                    end else begin
                        next_state_s = MEM_RD;
                    end
                end
                MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) begin
                        next_state_s = MEM_WB;
                    end else if (timeout_s) begin
                        next_state_s = FETCH;
                    end else begin
                        next_state_s = MEM_RD;
                    end
                end
                MEM_WB: begin
                    reg_write    = 1'b1;
                    mem_to_reg   = 1'b1;
                    next_state_s = FETCH;
                end
                MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) begin
                        next_state_s = FETCH;
                    end else if (timeout_s) begin
                        next_state_s = FETCH;
                    end else begin
                        next_state_s = MEM_WR;
                    end
                end
                EXEC_R: begin
                    alu_src_a    = 1'b1;
                    ALUOp        = 2'b10;
                    next_state_s = WB_R;
                end
                WB_R: begin
                    reg_write    = 1'b1;
                    reg_dst      = 1'b1;
                    next_state_s = FETCH;
                end
                EXEC_I: begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = 2'b10;
                    ALUOp        = 2'b11;
                    next_state_s = WB_I;
                end
                WB_I: begin
                    reg_write    = 1'b1;
                    next_state_s = FETCH;
                end
                BRANCH: begin
                    // The PC is written only if zero is 1. That gate is in the
                    // datapath, so zero is not used here.
                    alu_src_a     = 1'b1;
                    ALUOp         = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    next_state_s  = FETCH;
                end
                JUMP: begin
                    pc_write     = 1'b1;
                    pc_source    = 2'b10;
                    next_state_s = FETCH;
                end
                TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    illegal_op   = 1'b1;
                    next_state_s = TRAP;
`else
                    next_state_s = FETCH;
`endif
                end
                default: begin
                    next_state_s = FETCH;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RESET_STATE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Instruction register. It loads only when a fetch completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_r <= 16'h0000;
        end else if (ir_load_s) begin
            ir_r <= mem_rdata;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Wait counter for the memory handshake. It clears on any state change
    // and on a timeout. On a timeout in FETCH the state does not change, so
    // that case needs its own clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 8'd0;
        end else if (timeout_s || (next_state_s != state_r)) begin
            wait_cnt_r <= 8'd0;
        end else if (wait_state_s && !mem_ready) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Suppress unused warning: zero is consumed by the datapath PC gate.
    logic unused_zero_s;
    assign unused_zero_s = zero;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multicycle main control unit for the 16-bit CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and drives datapath enables.
- Latches the instruction register and supplies `ALUOp[1:0]`, `opcode[3:0]` and `Funct[1:0]` directly to the downstream ALU control unit.
- Handles a ready-based memory handshake with timeout.

Parameters:
- TIMEOUT_CYCLES, 15: maximum wait cycles for `mem_ready` before abort; range 1..255.
- RESET_STATE_FETCH, 1: fixed at 1; the FSM leaves reset in FETCH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_rdata  in  16  memory read data; the instruction word during FETCH.
- mem_ready  in  1  memory completes the current access this cycle.
- zero  in  1  ALU zero flag, used in BRANCH.
- ALUOp  out  2  00 add, 01 sub (BEQ), 10 R-type by Funct, 11 I-format by opcode.
- opcode  out  4  IR[15:12].
- Funct  out  2  IR[1:0].
- ir_write  out  1  IR load strobe (mirrors the internal latch).
- pc_write  out  1  unconditional PC update.
- pc_write_cond  out  1  PC update if zero.
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- mem_read, mem_write  out  1  memory strobes; held until mem_ready or timeout.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 reg B, 01 const 1, 10 sign-extended imm[5:0], 11 imm shifted.
- reg_write  out  1  register file write.
- reg_dst  out  1  1 = rd (IR[5:3]), 0 = rt (IR[8:6]).
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut.
- bus_error  out  1  one-cycle pulse on memory timeout.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset:
  - All outputs 0, `ALUOp` = 00, IR = 16'h0000, wait counter 0.
  - State is FETCH; first fetch strobes appear in the cycle after reset deasserts.
  - Reset asserted in any state, mid-access included, aborts within that edge.
- Opcode map:
  - 0000 R-type; 0001 LW; 0011 SW; 0100 BEQ; 0101 J.
  - 1001 ADDI; 1010 SUBI; 1011 SLTI; 0010 SLL/SRA (I-format).
  - All other opcodes are undefined.
- States (4-bit encoding):
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, WB_R=7, BRANCH=8, JUMP=9, EXEC_I=10, WB_I=11, TRAP=12.
- FETCH:
  - Drives `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `ALUOp`=00, `pc_source`=00.
  - On `mem_ready`: `ir_write`=1 and `pc_write`=1 in that same cycle, IR <= `mem_rdata`, next state DECODE.
  - Without `mem_ready`: remain in FETCH and increment the wait counter.
- DECODE (1 cycle):
  - Drives `alu_src_a`=0, `alu_src_b`=11, `ALUOp`=00 (branch target precompute).
  - Next state by opcode:
    - LW/SW -> MEM_ADDR
    - R -> EXEC_R
    - BEQ -> BRANCH
    - J -> JUMP
    - I-format -> EXEC_I
    - undefined -> see Optional Feature
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `ALUOp`=00; LW -> MEM_RD, SW -> MEM_WR.
- MEM_RD:
  - `mem_read`=1, `iord`=1.
  - On `mem_ready` -> MEM_WB.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0 -> FETCH.
- MEM_WR: `mem_write`=1, `iord`=1; on `mem_ready` -> FETCH.
- R-type path:
  - EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `ALUOp`=10 -> WB_R.
  - WB_R: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0 -> FETCH.
- I-format path:
  - EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `ALUOp`=11 -> WB_I.
  - WB_I: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 -> FETCH.
- BRANCH:
  - `alu_src_a`=1, `alu_src_b`=00, `ALUOp`=01, `pc_write_cond`=1, `pc_source`=01 -> FETCH.
  - PC updates only if `zero`=1.
- JUMP: `pc_write`=1, `pc_source`=10 -> FETCH.
- Wait counter:
  - Counts cycles in FETCH/MEM_RD/MEM_WR while `mem_ready`=0; clears on any state change.
  - At count == TIMEOUT_CYCLES with `mem_ready` still 0: `bus_error`=1 for one cycle, strobes drop, next state FETCH, no PC/IR/reg write.
  - `mem_ready` arriving in the timeout cycle itself wins: normal completion, no `bus_error`.
- Memory strobes:
  - `mem_read`/`mem_write` never asserted together.
  - Deassert in the cycle after `mem_ready` is seen.
- Outputs are combinational from state and IR (Moore, plus the `mem_ready` qualifier on `ir_write`/`pc_write` in FETCH).
- `opcode`/`Funct` stay stable from the DECODE cycle until the next IR load.
- Cycle counts with zero-wait memory:
  - R, I, LW-address-plus-writeback paths: 4 cycles (LW is 5 including MEM_RD).
  - SW: 4. BEQ, J: 3.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode in DECODE -> TRAP.
  - TRAP holds all strobes 0 and asserts extra output `illegal_op`=1.
  - Stays in TRAP until reset.
- Undefined:
  - Undefined opcodes act as NOP: DECODE -> FETCH, no writes.
  - No `illegal_op` port.

Test Plan:
- Reset, then `mem_ready`=1 each cycle, `mem_rdata`=16'h0_0C1 (R-type, Funct=01) -> state sequence 0,1,6,7,0; `ALUOp`=10 and `Funct`=01 in EXEC_R; `reg_write`=1 and `reg_dst`=1 in WB_R.
- Fetch 16'h9045 (ADDI) -> `ALUOp`=11, `opcode`=1001, `alu_src_b`=10 in EXEC_I; `reg_write`=1 and `reg_dst`=0 in WB_I.
- LW 16'h1083 with `mem_ready` delayed 3 cycles in MEM_RD -> `mem_read`=1 and `iord`=1 held 4 cycles; MEM_WB has `mem_to_reg`=1; total 8 cycles.
- BEQ 16'h4042, `zero`=1 and then `zero`=0 -> `ALUOp`=01 and `pc_write_cond`=1 in BRANCH; returns to FETCH after 3 cycles.
- FETCH with `mem_ready` held 0, TIMEOUT_CYCLES=15 -> `bus_error` pulses once at wait cycle 15, no `ir_write`/`pc_write`, FETCH restarts. Separately, reset pulsed during MEM_WR -> `mem_write`=0 and state 0 on the next cycle.
- Opcode 1111 -> with CTRL_ILLEGAL_TRAP_EN: state 12, `illegal_op`=1 held for 20 cycles. Without it: DECODE -> FETCH with no writes.
